// File: rtl/elev_pkg.sv
// Shared types and constants for the four-floor elevator controller.
package elev_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      MOVE_UP   = 2'b01,
      MOVE_DOWN = 2'b10,
      DOOR      = 2'b11
   } elev_state_e;

   localparam int NUM_FLOORS = 4;

   localparam logic [1:0] FLOOR1 = 2'b00;
   localparam logic [1:0] FLOOR2 = 2'b01;
   localparam logic [1:0] FLOOR3 = 2'b10;
   localparam logic [1:0] FLOOR4 = 2'b11;

   // One-hot of a floor code.
   function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] f);
      return 4'b0001 << f;
   endfunction

   // Floors strictly above f.
   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [1:0] f);
      return 4'b1110 << f;
   endfunction

   // Floors strictly below f.
   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [1:0] f);
      return (4'b0001 << f) - 4'b0001;
   endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Call-button and status bundle between the elevator controller and its
// surroundings (buttons, lamps, floor-number decoder).
interface elevator_ctrl_if;
   import elev_pkg::*;

   logic [NUM_FLOORS-1:0] req;
   logic [1:0]            floor;
   logic                  dir_up;
   logic                  moving;
   logic                  door_open;
   logic [NUM_FLOORS-1:0] pending;

   modport master (
      output req,
      input  floor, dir_up, moving, door_open, pending
   );

   modport slave (
      input  req,
      output floor, dir_up, moving, door_open, pending
   );
endinterface

// File: rtl/elev_timer.sv
// Loadable down-counter shared by travel and door dwell. A start pulse loads
// (cycles-1); done is high while the count sits at zero.
module elev_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] load_i,
   output logic             done_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count register: load on start, otherwise count down and hold at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {WIDTH{1'b0}};
      end else if (start_i) begin
         cnt_q <= load_i;
      end else if (cnt_q != {WIDTH{1'b0}}) begin
         cnt_q <= cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign done_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/elevator_ctrl.sv
// Four-floor collective elevator controller: latches calls, picks direction,
// times travel and door dwell, drives the floor code for the display decoder.
// Optional: define ELEV_DOOR_REOPEN_EN so a call for the current floor while
// the door is open restarts the dwell instead of being ignored.
module elevator_ctrl
   import elev_pkg::*;
#(
   parameter int MOVE_CYCLES = 50_000_000,
   parameter int DOOR_CYCLES = 100_000_000
) (
   input  logic            clk,
   input  logic            rst,
   elevator_ctrl_if.slave  elev_if
);

   localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES + 1);
   localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

   elev_state_e           state_q, state_d;
   logic [1:0]            floor_q, floor_d;
   logic                  dir_up_q, dir_up_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;

   logic [NUM_FLOORS-1:0] req_s;
   logic [NUM_FLOORS-1:0] clear_s;
   logic                  above_s, below_s;
   logic                  reopen_s;
   logic                  tmr_start_s;
   logic [TW-1:0]         tmr_load_s;
   logic                  tmr_done_s;

   elev_timer #(.WIDTH(TW)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start_i (tmr_start_s),
      .load_i  (tmr_load_s),
      .done_o  (tmr_done_s)
   );

   // Call filtering: the current floor's button never latches while the door is open.
   always_comb begin
      req_s    = elev_if.req;
      reopen_s = 1'b0;
      if (state_q == DOOR) begin
         req_s = elev_if.req & ~floor_onehot(floor_q);
`ifdef ELEV_DOOR_REOPEN_EN
         reopen_s = elev_if.req[floor_q];
`endif
      end else begin
         req_s = elev_if.req;
      end
      above_s = |(pending_q & above_mask(floor_q));
      below_s = |(pending_q & below_mask(floor_q));
   end

   // Scheduling FSM next state, timer control and request latch.
   always_comb begin
      state_d     = state_q;
      floor_d     = floor_q;
      dir_up_d    = dir_up_q;
      clear_s     = 4'b0000;
      tmr_start_s = 1'b0;
      tmr_load_s  = MOVE_LOAD;
      case (state_q)
         IDLE: begin
            if (pending_q[floor_q]) begin
               state_d     = DOOR;
               clear_s     = floor_onehot(floor_q);
               tmr_start_s = 1'b1;
               tmr_load_s  = DOOR_LOAD;
            end else if (dir_up_q ? above_s : !below_s && above_s) begin
               state_d     = MOVE_UP;
               dir_up_d    = 1'b1;
               tmr_start_s = 1'b1;
            end else if (below_s) begin
               state_d     = MOVE_DOWN;
               dir_up_d    = 1'b0;
               tmr_start_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         MOVE_UP: begin
            if (tmr_done_s) begin
               state_d = IDLE;
               floor_d = floor_q + 2'b01;
            end else begin
               state_d = MOVE_UP;
            end
         end
         MOVE_DOWN: begin
            if (tmr_done_s) begin
               state_d = IDLE;
               floor_d = floor_q - 2'b01;
            end else begin
               state_d = MOVE_DOWN;
            end
         end
         DOOR: begin
            if (reopen_s) begin
               tmr_start_s = 1'b1;
               tmr_load_s  = DOOR_LOAD;
            end else if (tmr_done_s) begin
               state_d = IDLE;
            end else begin
               state_d = DOOR;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      pending_d = (pending_q | req_s) & ~clear_s;
   end

   // State and status registers; reset abandons any travel or dwell at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         floor_q   <= FLOOR1;
         dir_up_q  <= 1'b1;
         pending_q <= 4'b0000;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_up_q  <= dir_up_d;
         pending_q <= pending_d;
      end
   end

   assign elev_if.floor     = floor_q;
   assign elev_if.dir_up    = dir_up_q;
   assign elev_if.pending   = pending_q;
   assign elev_if.moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
   assign elev_if.door_open = (state_q == DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: directed scenarios plus random calls,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_elevator_ctrl;
   import elev_pkg::*;

   localparam int MC = 4;
   localparam int DC = 3;
`ifdef ELEV_DOOR_REOPEN_EN
   localparam bit REOPEN = 1'b1;
`else
   localparam bit REOPEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   elevator_ctrl_if eif ();

   elevator_ctrl #(.MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
      .clk     (clk),
      .rst     (rst),
      .elev_if (eif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: mode 0 = idle, 1 = going up, 2 = going down, 3 = door open
   int         m_mode;
   int         m_floor;
   bit         m_dir;
   logic [3:0] m_pend;
   int         m_left;   // cycles remaining in current travel/dwell

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic [3:0] r, input bit do_rst);
      logic [3:0] latch;
      logic [3:0] clr;
      bit reopen;
      bit up_w, dn_w;
      int p;
      if (do_rst) begin
         m_mode = 0; m_floor = 0; m_dir = 1'b1; m_pend = 4'b0000; m_left = 0;
         return;
      end
      latch  = r;
      clr    = 4'b0000;
      reopen = 1'b0;
      if (m_mode == 3) begin
`ifdef ELEV_DOOR_REOPEN_EN
         reopen = r[m_floor];
`endif
         latch[m_floor] = 1'b0;
      end
      p    = int'(m_pend);
      up_w = (p >> (m_floor + 1)) != 0;
      dn_w = (p & ((1 << m_floor) - 1)) != 0;
      case (m_mode)
         0: begin
            if (m_pend[m_floor]) begin
               m_mode = 3; m_left = DC; clr[m_floor] = 1'b1;
            end else if (m_dir) begin
               if (up_w) begin m_mode = 1; m_left = MC; end
               else if (dn_w) begin m_mode = 2; m_left = MC; m_dir = 1'b0; end
            end else begin
               if (dn_w) begin m_mode = 2; m_left = MC; end
               else if (up_w) begin m_mode = 1; m_left = MC; m_dir = 1'b1; end
            end
         end
         1, 2: begin
            if (m_left == 1) begin
               m_floor = (m_mode == 1) ? m_floor + 1 : m_floor - 1;
               m_mode  = 0;
            end else m_left--;
         end
         default: begin
            if (reopen) m_left = DC;
            else if (m_left == 1) m_mode = 0;
            else m_left--;
         end
      endcase
      m_pend = (m_pend | latch) & ~clr;
   endtask

   task automatic compare_all();
      chk("floor",     eif.floor,     m_floor);
      chk("dir_up",    eif.dir_up,    m_dir);
      chk("pending",   eif.pending,   m_pend);
      chk("moving",    eif.moving,    (m_mode == 1 || m_mode == 2));
      chk("door_open", eif.door_open, (m_mode == 3));
   endtask

   // apply inputs for one cycle, advance model at the edge, check just after it
   task automatic tick(input logic [3:0] r, input bit do_rst);
      eif.req = r;
      rst     = do_rst;
      @(posedge clk);
      model_step(r, do_rst);
      #1;
      compare_all();
   endtask

   initial begin
      int n_door;
      int doors [2];
      bit prev_door;
      logic [3:0] rq;

      eif.req = 4'b0000;
      rst     = 1'b1;
      tick(4'b0000, 1'b1);
      tick(4'b0000, 1'b1);

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         tick(4'b0000, 1'b0);
         chk("s1_floor", eif.floor, 0);
         chk("s1_dir", eif.dir_up, 1);
         chk("s1_busy", {eif.moving, eif.door_open, eif.pending}, 0);
      end

      // travel 00 -> 10 with timeline checks
      for (int c = 1; c <= 15; c++) begin
         tick((c == 1) ? 4'b0100 : 4'b0000, 1'b0);
         if (c == 1) chk("s2_pend", eif.pending, 4'b0100);
         if (c >= 2 && c <= 5) chk("s2_mv1", eif.moving, 1);
         if (c == 6) chk("s2_f01", {eif.floor, eif.moving}, {2'b01, 1'b0});
         if (c >= 7 && c <= 10) chk("s2_mv2", eif.moving, 1);
         if (c == 11) chk("s2_f10", {eif.floor, eif.moving}, {2'b10, 1'b0});
         if (c >= 12 && c <= 14) chk("s2_door", {eif.door_open, eif.pending}, {1'b1, 4'b0000});
         if (c == 15) chk("s2_close", {eif.door_open, eif.moving}, 0);
      end

      // at 10 heading up, calls 11 and 00: serve 11 first, then reverse
      tick(4'b1001, 1'b0);
      n_door = 0; prev_door = 1'b0;
      for (int i = 0; i < 80 && !(n_door == 2 && !eif.door_open); i++) begin
         tick(4'b0000, 1'b0);
         if (eif.door_open && !prev_door && n_door < 2) begin
            doors[n_door] = int'(eif.floor);
            n_door++;
         end
         prev_door = eif.door_open;
      end
      chk("s3_ndoor", n_door, 2);
      if (n_door == 2) begin
         chk("s3_first", doors[0], 3);
         chk("s3_second", doors[1], 0);
      end
      chk("s3_dir", eif.dir_up, 0);

      // go to floor 01, open door there; re-press during commit does not re-latch
      tick(4'b0010, 1'b0);
      for (int i = 0; i < 20 && !(eif.floor == 2'b01 && !eif.moving); i++) tick(4'b0000, 1'b0);
      chk("s4_reach", {eif.floor, eif.moving, eif.pending}, {2'b01, 1'b0, 4'b0010});
      tick(4'b0010, 1'b0);
      chk("s4_door", {eif.door_open, eif.moving, eif.pending}, {1'b1, 1'b0, 4'b0000});
      tick(4'b0000, 1'b0);
      tick(4'b0000, 1'b0);
      tick(4'b0010, 1'b0);   // pressed during the last dwell cycle
      chk("s5_door_a", {eif.door_open, eif.pending}, {REOPEN, 4'b0000});
      tick(4'b0000, 1'b0);
      chk("s5_door_b", eif.door_open, REOPEN);
      tick(4'b0000, 1'b0);
      chk("s5_door_c", eif.door_open, REOPEN);
      tick(4'b0000, 1'b0);
      chk("s5_closed", eif.door_open, 0);

      // reset in the middle of upward travel
      tick(4'b1000, 1'b0);
      tick(4'b0000, 1'b0);
      tick(4'b0000, 1'b0);
      chk("s6_moving", eif.moving, 1);
      tick(4'b0000, 1'b1);
      chk("s6_rst", {eif.floor, eif.dir_up, eif.moving, eif.door_open, eif.pending},
          {2'b00, 1'b1, 1'b0, 1'b0, 4'b0000});
      tick(4'b0001, 1'b0);
      chk("s6_pend", eif.pending, 4'b0001);
      tick(4'b0000, 1'b0);
      chk("s6_door", {eif.floor, eif.moving, eif.door_open}, {2'b00, 1'b0, 1'b1});

      // random calls with occasional reset
      for (int i = 0; i < 800; i++) begin
         rq = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
         tick(rq, $urandom_range(0, 299) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
